// File: rtl/noc_pkg.sv
// Shared router types: flit encodings, output-arbiter FSM states and requester count.
package noc_pkg;

    localparam int PORT_N = 5;
    localparam int VCH_N  = 2;
    localparam int REQ_N  = PORT_N * VCH_N;

    typedef enum logic [1:0] {
        TYPE_HEAD     = 2'd0,
        TYPE_BODY     = 2'd1,
        TYPE_TAIL     = 2'd2,
        TYPE_HEADTAIL = 2'd3
    } flit_type_e;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } outarb_state_e;

    // Upstream uses this to derive tail_i from the flit type being sent.
    function automatic logic is_tail(flit_type_e t);
        return (t == TYPE_TAIL) || (t == TYPE_HEADTAIL);
    endfunction

endpackage

// File: rtl/noc_out_arb_if.sv
// Switch-allocation handshake between the input VCs (master) and one output arbiter (slave).
interface noc_out_arb_if #(
    parameter int REQ_N = noc_pkg::REQ_N,
    parameter int IDX_W = $clog2(REQ_N)
);

    logic [REQ_N-1:0] req_i;
    logic [REQ_N-1:0] send_i;
    logic [REQ_N-1:0] tail_i;
    logic [REQ_N-1:0] grt_o;
    logic [IDX_W-1:0] gidx_o;
    logic             busy_o;
    logic             err_o;

    modport master (
        output req_i, send_i, tail_i,
        input  grt_o, gidx_o, busy_o, err_o
    );

    modport slave (
        input  req_i, send_i, tail_i,
        output grt_o, gidx_o, busy_o, err_o
    );

endinterface

// File: rtl/noc_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping via a double-width scan.
module noc_rr_pick #(
    parameter int N     = 10,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [2*N-1:0] req_dbl;

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        req_dbl = {req, req};
        found   = 1'b0;
        idx     = '0;
        // Scanning downward lets the lowest position inside the window win.
        for (int i = 2*N-1; i >= 0; i--) begin
            if (req_dbl[i] && (i >= int'(ptr)) && (i < int'(ptr) + N)) begin
                found = 1'b1;
                idx   = (i >= N) ? IDX_W'(i - N) : IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/noc_out_arb.sv
// Packet-level round-robin switch arbiter for one output port.
// Optional watchdog release enabled by defining NOC_OUTARB_WDOG_EN.
module noc_out_arb #(
    parameter int ROUTERID = 0,
    parameter int PCHID    = 0,
    parameter int REQ_N    = noc_pkg::REQ_N,
    parameter int WDOG_CYC = 64
) (
    input  logic         clk,
    input  logic         rst,
    noc_out_arb_if.slave arb
);

    import noc_pkg::*;

    localparam int IDX_W = $clog2(REQ_N);

    if (WDOG_CYC < 2 || ROUTERID < 0 || PCHID < 0) begin : g_bad_param
        $error("noc_out_arb: WDOG_CYC must be >= 2 and ids non-negative");
    end

    outarb_state_e    state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] gidx_q, gidx_d;
    logic [REQ_N-1:0] grt_q, grt_d;
    logic             busy_q, busy_d;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic             g_req, g_send, g_tail;
    logic             rel;

    noc_rr_pick #(.N(REQ_N), .IDX_W(IDX_W)) u_pick (
        .req   (arb.req_i),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign g_req  = arb.req_i[gidx_q];
    assign g_send = arb.send_i[gidx_q];
    assign g_tail = arb.tail_i[gidx_q];

`ifdef NOC_OUTARB_WDOG_EN
    localparam int CNT_W = $clog2(WDOG_CYC);

    logic [CNT_W-1:0] wdog_q, wdog_d;
    logic             err_q, err_d;
    logic             wdog_expire;

    assign wdog_expire = (wdog_q == CNT_W'(WDOG_CYC - 1)) && !g_send;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        grt_d   = grt_q;
        busy_d  = busy_q;
        rel     = 1'b0;
`ifdef NOC_OUTARB_WDOG_EN
        wdog_d  = wdog_q;
        err_d   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = HOLD;
                    grt_d   = REQ_N'(1) << pick_idx;
                    gidx_d  = pick_idx;
                    busy_d  = 1'b1;
                    ptr_d   = (pick_idx == IDX_W'(REQ_N - 1)) ? '0 : pick_idx + 1'b1;
`ifdef NOC_OUTARB_WDOG_EN
                    wdog_d  = '0;
`endif
                end
            end
            HOLD: begin
                rel = (g_send && g_tail) || !g_req;
`ifdef NOC_OUTARB_WDOG_EN
                // Only a hang with the requester still present is reported as an error.
                err_d  = wdog_expire && !rel;
                rel    = rel || wdog_expire;
                wdog_d = g_send ? '0 : wdog_q + 1'b1;
`endif
            end
        endcase
        if (rel) begin
            state_d = IDLE;
            grt_d   = '0;
            gidx_d  = '0;
            busy_d  = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gidx_q  <= '0;
            grt_q   <= '0;
            busy_q  <= 1'b0;
`ifdef NOC_OUTARB_WDOG_EN
            wdog_q  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            grt_q   <= grt_d;
            busy_q  <= busy_d;
`ifdef NOC_OUTARB_WDOG_EN
            wdog_q  <= wdog_d;
            err_q   <= err_d;
`endif
        end
    end

    assign arb.grt_o  = grt_q;
    assign arb.gidx_o = gidx_q;
    assign arb.busy_o = busy_q;
`ifdef NOC_OUTARB_WDOG_EN
    assign arb.err_o  = err_q;
`else
    assign arb.err_o  = 1'b0;
`endif

endmodule
